// File: rtl/otp_pkg.sv
// otp_pkg: shared letter width, alphabet bound, state encoding and plaintext slot helper
package otp_pkg;
    localparam int LETTER_W = 5;
    localparam logic [LETTER_W-1:0] ALPHA_MAX = 5'd25;
    localparam int DEF_N_CHARS = 4;
    typedef enum logic [2:0] {S_LOAD, S_ISSUE, S_WAIT, S_GAPW, S_FLUSH, S_FLUSH_WAIT, S_DONE} state_t;
    function automatic int slot_lsb(input int i);
        return i * LETTER_W;
    endfunction
endpackage

// File: rtl/otp_char_buffer.sv
// otp_char_buffer: N_CHARS x (text, key) letter store with write pointer, read port and range check
module otp_char_buffer
    import otp_pkg::*;
#(
    parameter int N_CHARS = DEF_N_CHARS,
    localparam int IW = N_CHARS > 1 ? $clog2(N_CHARS) : 1,
    localparam int PW = $clog2(N_CHARS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                we,
    input  logic [LETTER_W-1:0] wr_text,
    input  logic [LETTER_W-1:0] wr_key,
    input  logic [IW-1:0]       rd_idx,
    output logic [LETTER_W-1:0] rd_text,
    output logic [LETTER_W-1:0] rd_key,
    output logic                full,
    output logic                range_err
);
    logic [LETTER_W-1:0] text_q [N_CHARS];
    logic [LETTER_W-1:0] key_q [N_CHARS];
    logic [PW-1:0] wr_ptr;
    logic [IW-1:0] wr_idx;
    logic bad;
    assign wr_idx = clr ? '0 : wr_ptr[IW-1:0];
    assign bad = we && (wr_text > ALPHA_MAX || wr_key > ALPHA_MAX);
    assign full = wr_ptr == PW'(N_CHARS);
    assign rd_text = text_q[rd_idx];
    assign rd_key = key_q[rd_idx];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            range_err <= 1'b0;
        end else begin
            wr_ptr <= (clr ? '0 : wr_ptr) + PW'(we);
            range_err <= (range_err && !clr) || bad;
        end
    always_ff @(posedge clk)
        if (we) begin
            text_q[wr_idx] <= wr_text;
            key_q[wr_idx] <= wr_key;
        end
endmodule

// File: rtl/otp_decrypt_sequencer.sv
// otp_decrypt_sequencer: buffers a message, feeds it letter by letter to the OTP datapath,
// collects the plaintext and flushes the datapath letter counter at the end of each run
module otp_decrypt_sequencer
    import otp_pkg::*;
#(
    parameter int N_CHARS = DEF_N_CHARS,
    parameter int GAP = 0,
    parameter int TIMEOUT = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        abort,
    input  logic                        load_valid,
    input  logic [LETTER_W-1:0]         load_text,
    input  logic [LETTER_W-1:0]         load_key,
    output logic                        load_ready,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        range_err,
    output logic                        timeout_err,
    output logic                        dp_rst_n,
    output logic                        dp_enable,
    output logic [LETTER_W-1:0]         dp_text,
    output logic [LETTER_W-1:0]         dp_key,
    input  logic                        dp_enable_next,
    input  logic [LETTER_W-1:0]         dp_decrypted,
    output logic [LETTER_W*N_CHARS-1:0] plain_out
);
    localparam int IW = N_CHARS > 1 ? $clog2(N_CHARS) : 1;
    localparam int CW = $clog2(GAP + TIMEOUT + 1);
    state_t state_q, state_d;
    logic [IW-1:0] rd_ptr, rd_nxt;
    logic [CW-1:0] cnt;
    logic [LETTER_W-1:0] rd_text, rd_key;
    logic full, we, clr, accept, got, last, rst_seen;
    assign load_ready = !full;
    assign accept = state_q == S_LOAD && start && full && !range_err;
    assign got = state_q == S_WAIT && dp_enable_next;
    assign last = rd_ptr == IW'(N_CHARS - 1);
    assign we = !abort && load_valid && (state_q == S_DONE || (state_q == S_LOAD && !full));
    assign clr = abort || (state_q == S_DONE && load_valid);
    otp_char_buffer #(.N_CHARS(N_CHARS)) u_buf (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .we(we),
        .wr_text(load_text),
        .wr_key(load_key),
        .rd_idx(rd_nxt),
        .rd_text(rd_text),
        .rd_key(rd_key),
        .full(full),
        .range_err(range_err)
    );
    always_comb begin
        state_d = state_q;
        rd_nxt = rd_ptr;
        if (abort) begin
            state_d = S_LOAD;
            rd_nxt = '0;
        end else
            case (state_q)
                S_LOAD: if (accept) begin
                    state_d = S_ISSUE;
                    rd_nxt = '0;
                end
                S_ISSUE: state_d = S_WAIT;
                S_WAIT: if (got) begin
                    state_d = last ? S_FLUSH : (GAP > 0 ? S_GAPW : S_ISSUE);
                    rd_nxt = last ? rd_ptr : rd_ptr + 1'b1;
                end else if (cnt == CW'(TIMEOUT - 1))
                    state_d = S_DONE;
                S_GAPW: if (cnt == CW'(GAP - 1)) state_d = S_ISSUE;
                S_FLUSH: state_d = S_FLUSH_WAIT;
                S_FLUSH_WAIT: state_d = S_DONE;
                S_DONE: if (load_valid) state_d = S_LOAD;
                default: state_d = S_LOAD;
            endcase
    end
    // dp_rst_n stays low for one edge after reset release and for one cycle per abort
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= S_LOAD;
            rd_ptr <= '0;
            cnt <= '0;
            rst_seen <= 1'b0;
            dp_rst_n <= 1'b0;
            dp_enable <= 1'b0;
            dp_text <= '0;
            dp_key <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            timeout_err <= 1'b0;
            plain_out <= '0;
        end else begin
            state_q <= state_d;
            rd_ptr <= rd_nxt;
            cnt <= state_d == state_q ? cnt + 1'b1 : '0;
            rst_seen <= 1'b1;
            dp_rst_n <= rst_seen && !abort;
            dp_enable <= state_d inside {S_ISSUE, S_FLUSH};
            dp_text <= state_d == S_ISSUE ? rd_text : '0;
            dp_key <= state_d == S_ISSUE ? rd_key : '0;
            busy <= state_d inside {S_ISSUE, S_WAIT, S_GAPW, S_FLUSH, S_FLUSH_WAIT};
            done <= state_d == S_DONE;
            timeout_err <= !clr && (timeout_err || (state_q == S_WAIT && state_d == S_DONE));
            if (accept && !abort)
                plain_out <= '0;
            else if (got && !abort)
                plain_out[slot_lsb(int'(rd_ptr)) +: LETTER_W] <= dp_decrypted;
        end
endmodule

// File: tb/tb_otp_decrypt_sequencer.sv
// tb_otp_decrypt_sequencer: directed runs on a GAP=0 and a GAP=3 sequencer against a
// behavioural datapath model; expectations are queued at stimulus time and popped by a monitor
module tb_otp_decrypt_sequencer;
    import otp_pkg::*;
    localparam int N = 4;
    localparam int PW = LETTER_W * N;
    localparam logic [PW-1:0] T1 = {5'd25, 5'd20, 5'd10, 5'd7};
    localparam logic [PW-1:0] K1 = {5'd0, 5'd5, 5'd4, 5'd3};
    localparam logic [PW-1:0] P1 = {5'd25, 5'd15, 5'd6, 5'd4};
    localparam logic [PW-1:0] T2 = {4{5'd2}};
    localparam logic [PW-1:0] K2 = {4{5'd5}};
    localparam logic [PW-1:0] P2 = {4{5'd24}};
    localparam logic [PW-1:0] T3 = {5'd4, 5'd3, 5'd2, 5'd1};
    localparam logic [PW-1:0] K3 = {5'd4, 5'd27, 5'd2, 5'd1};
    localparam logic [PW-1:0] T4 = {5'd3, 5'd13, 5'd5, 5'd0};
    localparam logic [PW-1:0] K4 = {5'd20, 5'd13, 5'd9, 5'd0};
    localparam logic [PW-1:0] P4 = {5'd10, 5'd0, 5'd23, 5'd0};

    typedef struct packed { int cyc; logic [4:0] t; logic [4:0] k; } issue_t;
    typedef struct packed { int d; int cyc; logic [PW-1:0] plain; logic terr; } done_t;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic load_valid[2], start[2], abort[2], withhold[2];
    logic [4:0] load_text[2], load_key[2];
    logic load_ready[2], busy[2], done[2], range_err[2], timeout_err[2];
    logic dp_rst_n[2], dp_enable[2], dp_enable_next[2];
    logic [4:0] dp_text[2], dp_key[2], dp_decrypted[2];
    logic [PW-1:0] plain_out[2];

    otp_decrypt_sequencer #(.N_CHARS(N), .GAP(0), .TIMEOUT(8)) u_dut (
        .clk(clk), .rst(rst), .abort(abort[0]),
        .load_valid(load_valid[0]), .load_text(load_text[0]), .load_key(load_key[0]),
        .load_ready(load_ready[0]), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .range_err(range_err[0]), .timeout_err(timeout_err[0]), .dp_rst_n(dp_rst_n[0]),
        .dp_enable(dp_enable[0]), .dp_text(dp_text[0]), .dp_key(dp_key[0]),
        .dp_enable_next(dp_enable_next[0]), .dp_decrypted(dp_decrypted[0]),
        .plain_out(plain_out[0])
    );
    otp_decrypt_sequencer #(.N_CHARS(N), .GAP(3), .TIMEOUT(8)) u_gap (
        .clk(clk), .rst(rst), .abort(abort[1]),
        .load_valid(load_valid[1]), .load_text(load_text[1]), .load_key(load_key[1]),
        .load_ready(load_ready[1]), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .range_err(range_err[1]), .timeout_err(timeout_err[1]), .dp_rst_n(dp_rst_n[1]),
        .dp_enable(dp_enable[1]), .dp_text(dp_text[1]), .dp_key(dp_key[1]),
        .dp_enable_next(dp_enable_next[1]), .dp_decrypted(dp_decrypted[1]),
        .plain_out(plain_out[1])
    );

    function automatic logic [4:0] dec(input logic [4:0] c, input logic [4:0] k);
        return c >= k ? c - k : 5'(26 - (k - c - 1));
    endfunction

    // Datapath: answers one cycle after enable; after N letters the next enable only rewinds it
    int dcnt[2];
    always @(posedge clk)
        for (int d = 0; d < 2; d++)
            if (!dp_rst_n[d]) begin
                dcnt[d] <= 0;
                dp_enable_next[d] <= 1'b0;
                dp_decrypted[d] <= 5'd0;
            end else begin
                dp_enable_next[d] <= dp_enable[d] && !(withhold[d] && dcnt[d] == 0);
                if (dp_enable[d]) begin
                    dcnt[d] <= dcnt[d] == N ? 0 : dcnt[d] + 1;
                    dp_decrypted[d] <= dcnt[d] == N ? 5'd0 : dec(dp_text[d], dp_key[d]);
                end
            end

    int checks = 0, passed = 0, c0 = 0;
    issue_t iq[$];
    done_t dq[$];
    issue_t ie;
    done_t de;
    logic done_prev[2] = '{1'b0, 1'b0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (dp_enable[0]) begin
            check("issue_expected", 32'(iq.size() != 0), 1);
            if (iq.size() != 0) begin
                ie = iq.pop_front();
                check("issue_cycle", cyc, ie.cyc);
                check("issue_letter", 32'({dp_text[0], dp_key[0]}), 32'({ie.t, ie.k}));
            end
        end
        for (int d = 0; d < 2; d++) begin
            if (done[d] && !done_prev[d]) begin
                check("done_expected", 32'(dq.size() != 0), 1);
                if (dq.size() != 0) begin
                    de = dq.pop_front();
                    check("done_inst", d, de.d);
                    check("done_cycle", cyc, de.cyc);
                    check("plain_out", 32'(plain_out[d]), 32'(de.plain));
                    check("timeout_err", 32'(timeout_err[d]), 32'(de.terr));
                    check("busy_at_done", 32'(busy[d]), 0);
                end
            end
            done_prev[d] = done[d];
        end
    end

    function automatic logic [4:0] lt(input logic [PW-1:0] v, input int i);
        return v[5*i +: 5];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int d, input logic [4:0] t, input logic [4:0] k);
        load_valid[d] = 1'b1;
        load_text[d] = t;
        load_key[d] = k;
        tick();
        load_valid[d] = 1'b0;
    endtask

    task automatic load_all(input int d, input logic [PW-1:0] tv, input logic [PW-1:0] kv);
        for (int i = 0; i < N; i++) load(d, lt(tv, i), lt(kv, i));
    endtask

    task automatic go(input int d);
        start[d] = 1'b1;
        c0 = cyc;
        tick();
        start[d] = 1'b0;
    endtask

    task automatic expect_run0(input logic [PW-1:0] tv, input logic [PW-1:0] kv, input logic [PW-1:0] pv);
        for (int i = 0; i < N; i++) iq.push_back('{c0 + 1 + 2 * i, lt(tv, i), lt(kv, i)});
        iq.push_back('{c0 + 3 + (N - 1) * 2, 5'd0, 5'd0});
        dq.push_back('{0, c0 + 5 + (N - 1) * 2, pv, 1'b0});
    endtask

    task automatic wait_done(input int d);
        int n = 0;
        while (!done[d] && n < 100) begin
            tick();
            n++;
        end
        check("done_seen", 32'(done[d]), 1);
        tick();
    endtask

    task automatic run0(input logic [PW-1:0] tv, input logic [PW-1:0] kv, input logic [PW-1:0] pv);
        load_all(0, tv, kv);
        go(0);
        expect_run0(tv, kv, pv);
        wait_done(0);
    endtask

    task automatic do_abort(input int d);
        abort[d] = 1'b1;
        tick();
        abort[d] = 1'b0;
        check("abort_state", 32'({dp_rst_n[d], busy[d], done[d], range_err[d], timeout_err[d], load_ready[d]}), 32'b000001);
        tick();
        check("abort_dp_rst_n_back", 32'(dp_rst_n[d]), 1);
    endtask

    task automatic check_reset(input int d);
        check("rst_flags", 32'({load_ready[d], busy[d], done[d], range_err[d], timeout_err[d], dp_enable[d], dp_rst_n[d]}), 32'h40);
        check("rst_dp_data", 32'({dp_text[d], dp_key[d]}), 0);
        check("rst_plain", 32'(plain_out[d]), 0);
    endtask

    task automatic release_rst();
        rst = 1'b0;
        tick();
        check("dp_rst_n_edge1", 32'({dp_rst_n[0], dp_rst_n[1]}), 0);
        tick();
        check("dp_rst_n_edge2", 32'({dp_rst_n[0], dp_rst_n[1]}), 3);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            load_valid[d] = 1'b0;
            start[d] = 1'b0;
            abort[d] = 1'b0;
            withhold[d] = 1'b0;
            load_text[d] = 5'd0;
            load_key[d] = 5'd0;
        end
        tick();
        tick();
        check_reset(0);
        check_reset(1);
        release_rst();

        run0(T1, K1, P1);
        run0(T2, K2, P2);
        run0(T2, K2, P2);

        load_all(0, T3, K3);
        check("range_err_set", 32'(range_err[0]), 1);
        go(0);
        check("range_start_ignored", 32'({busy[0], load_ready[0]}), 0);
        do_abort(0);

        for (int i = 0; i < 3; i++) load(0, lt(T4, i), lt(K4, i));
        check("partial_ready", 32'(load_ready[0]), 1);
        go(0);
        check("partial_start_ignored", 32'(busy[0]), 0);
        load_valid[0] = 1'b1;
        load_text[0] = lt(T4, 3);
        load_key[0] = lt(K4, 3);
        start[0] = 1'b1;
        tick();
        load_valid[0] = 1'b0;
        start[0] = 1'b0;
        check("same_cycle_start_ignored", 32'({busy[0], load_ready[0]}), 0);
        go(0);
        check("start_accepted", 32'(busy[0]), 1);
        expect_run0(T4, K4, P4);
        wait_done(0);

        withhold[0] = 1'b1;
        load_all(0, T1, K1);
        go(0);
        iq.push_back('{c0 + 1, lt(T1, 0), lt(K1, 0)});
        dq.push_back('{0, c0 + 10, '0, 1'b1});
        wait_done(0);
        withhold[0] = 1'b0;
        do_abort(0);

        load_all(0, T1, K1);
        go(0);
        iq.push_back('{c0 + 1, lt(T1, 0), lt(K1, 0)});
        iq.push_back('{c0 + 3, lt(T1, 1), lt(K1, 1)});
        tick();
        tick();
        tick();
        check("busy_in_wait", 32'(busy[0]), 1);
        do_abort(0);
        run0(T1, K1, P1);

        load_all(1, T1, K1);
        go(1);
        tick();
        tick();
        tick();
        check("gapw_busy_idle_dp", 32'({busy[1], dp_enable[1]}), 2);
        rst = 1'b1;
        #2;
        check_reset(1);
        check_reset(0);
        @(posedge clk);
        #1;
        release_rst();
        load_all(1, T2, K2);
        go(1);
        dq.push_back('{1, c0 + 5 + (N - 1) * 5, P2, 1'b0});
        wait_done(1);

        check("issue_q_drained", 32'(iq.size()), 0);
        check("done_q_drained", 32'(dq.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end
endmodule
